// File: rtl/hazard_unit.sv
// Hazard responder for the 5-stage ARM pipeline: operand forwarding, load-use and PC-write stalls/flushes,
// and the data-memory wait FSM with sticky timeout. Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic       mem_miss;
  logic       mem_stall;
  logic       ld_stall;
  logic       pc_wr_pend;

  // R15 reads come from the PC path, never from a forwarded result.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       we_m,
    input logic [3:0] wa_m,
    input logic       we_w,
    input logic [3:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'd15) begin
      if (we_m && (wa_m == ra))      sel = 2'b10;
      else if (we_w && (wa_w == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign mem_miss   = MemReqM & ~MemReadyM;
  assign ld_stall   = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D)) & ~BranchTakenE;
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
  // A ready (or dropped request) in WAIT releases the pipe in that same cycle.
  assign mem_stall  = (state_q == ST_ERR) | mem_miss;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_miss) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (!mem_miss) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign MemTimeout = timeout_q;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (reset) begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
        FlushE = ld_stall | BranchTakenE;
        FlushW = 1'b0;
        StallF = ld_stall | pc_wr_pend;
        StallD = ld_stall & ~FlushD;
        StallE = 1'b0;
        StallM = 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((StallF | StallD | StallE | StallM) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((FlushD | FlushE) && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_unit;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [11:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: consecutive missed memory cycles and the sticky error.
  int m_waits = 0;
  bit m_err   = 1'b0;

  localparam logic [11:0] RESET_VEC = 12'b00_00_0000_111_0;

  hazard_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_waits <= 0;
      m_err   <= 1'b0;
    end else if (!m_err) begin
      if (MemReqM && !MemReadyM) begin
        m_waits <= m_waits + 1;
        if (m_waits + 1 >= TO) m_err <= 1'b1;
      end else begin
        m_waits <= 0;
      end
    end
  end

  function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model_out();
    logic ld, pcw, ms, sf, sd, se, sm, fd, fe, fw;
    if (!reset) return RESET_VEC;
    ld  = MemtoRegE && (WA3E == RA1D || WA3E == RA2D) && !BranchTakenE;
    pcw = PCSrcD || PCSrcE || PCSrcM;
    ms  = m_err || (MemReqM && !MemReadyM);
    if (ms) begin
      {sf, sd, se, sm, fd, fe, fw} = 7'b1111_001;
    end else begin
      fd = pcw || PCSrcW || BranchTakenE;
      fe = ld || BranchTakenE;
      sf = ld || pcw;
      sd = ld && !fd;
      se = 1'b0;
      sm = 1'b0;
      fw = 1'b0;
    end
    return {exp_fwd(RA1E), exp_fwd(RA2E), sf, sd, se, sm, fd, fe, fw, m_err};
  endfunction

  task automatic idle_inputs();
    {RA1D, RA2D, RA1E, RA2E} = {4'd4, 4'd5, 4'd6, 4'd7};
    {WA3E, WA3M, WA3W} = {4'd8, 4'd9, 4'd10};
    {RegWriteM, RegWriteW, MemtoRegE} = 3'b000;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = 5'b00000;
    MemReqM   = 1'b0;
    MemReadyM = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_reg();
    if ($urandom_range(0, 5) == 0) return 4'd15;
    return 4'($urandom_range(0, 4));
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    RA1E = 4'd3; RA2E = 4'd3; WA3M = 4'd3; WA3W = 4'd3;
    RegWriteM = 1'b1; RegWriteW = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcD = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b", obs, RESET_VEC);
    end
    $display("txn reset_outputs obs=%b", obs);
    idle_inputs();
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %b want %b", obs, 12'b0);
    end
    $display("txn reset_release_idle obs=%b", obs);
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
    @(negedge clk);
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      n_bad++;
      $display("FAIL fwd_m_priority: got %b want %b", {ForwardAE, ForwardBE}, 4'b1010);
    end
    $display("txn fwd_m_priority fa=%b fb=%b", ForwardAE, ForwardBE);
    tick();
    RegWriteM = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) begin
      n_bad++;
      $display("FAIL fwd_w_only: got %b want %b", {ForwardAE, ForwardBE}, 4'b0101);
    end
    $display("txn fwd_w_only fa=%b fb=%b", ForwardAE, ForwardBE);
    tick();
    RegWriteM = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15; RA2E = 4'd2;
    @(negedge clk);
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      n_bad++;
      $display("FAIL fwd_r15: got %b want %b", {ForwardAE, ForwardBE}, 4'b0000);
    end
    $display("txn fwd_r15 fa=%b fb=%b", ForwardAE, ForwardBE);
    tick();
  endtask

  task automatic test_ldstall();
    idle_inputs();
    MemtoRegE = 1'b1; WA3E = 4'd1; RA2D = 4'd1;
    @(negedge clk);
    n_cmp++;
    if ({StallF, StallD, FlushE, FlushD, StallE} !== 5'b11100) begin
      n_bad++;
      $display("FAIL ldstall: got %b want %b", {StallF, StallD, FlushE, FlushD, StallE}, 5'b11100);
    end
    $display("txn ldstall sf=%b sd=%b fe=%b", StallF, StallD, FlushE);
    tick();
    // LDR moves to M, bubble sits in E, dependent still in D.
    idle_inputs();
    RA2D = 4'd1; RegWriteM = 1'b1; WA3M = 4'd1;
    @(negedge clk);
    n_cmp++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      n_bad++;
      $display("FAIL ldstall_release: got %b want %b", {StallF, StallD, FlushE}, 3'b000);
    end
    $display("txn ldstall_release sf=%b sd=%b fe=%b", StallF, StallD, FlushE);
    tick();
    idle_inputs();
    RA2E = 4'd1; RegWriteW = 1'b1; WA3W = 4'd1;
    @(negedge clk);
    n_cmp++;
    if (ForwardBE !== 2'b01) begin
      n_bad++;
      $display("FAIL ldstall_fwd_w: got %b want %b", ForwardBE, 2'b01);
    end
    $display("txn ldstall_fwd_w fb=%b", ForwardBE);
    tick();
  endtask

  task automatic test_branch();
    logic [3:0] pcs [4];
    pcs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    idle_inputs();
    BranchTakenE = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    @(negedge clk);
    n_cmp++;
    if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
      n_bad++;
      $display("FAIL branch_taken: got %b want %b", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    end
    $display("txn branch_taken fd=%b fe=%b sf=%b", FlushD, FlushE, StallF);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = pcs[i];
      @(negedge clk);
      n_cmp++;
      if ({StallF, FlushD, StallD} !== {(i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL pc_write_stage%0d: got %b want %b", i, {StallF, FlushD, StallD},
                 {(i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0});
      end
      $display("txn pc_write_stage%0d sf=%b fd=%b", i, StallF, FlushD);
      tick();
    end
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      MemReqM = 1'b1; MemReadyM = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1111001) begin
        n_bad++;
        $display("FAIL mem_wait_cycle%0d: got %b want %b", i,
                 {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b1111001);
      end
      $display("txn mem_wait_cycle%0d stalls=%b fw=%b", i, {StallF, StallD, StallE, StallM}, FlushW);
      tick();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b00000) begin
      n_bad++;
      $display("FAIL mem_ready_release: got %b want %b", {StallF, StallD, StallE, StallM, FlushW}, 5'b00000);
    end
    $display("txn mem_ready_release stalls=%b", {StallF, StallD, StallE, StallM});
    tick();
    // Same-cycle ready: no stall at all, and nothing lingers the cycle after.
    MemReqM = 1'b1; MemReadyM = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (StallM !== 1'b0) begin
      n_bad++;
      $display("FAIL mem_ready_same_cycle: got %b want %b", StallM, 1'b0);
    end
    $display("txn mem_ready_same_cycle sm=%b", StallM);
    tick();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    tick();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({StallF, StallM, FlushW} !== 3'b000) begin
      n_bad++;
      $display("FAIL mem_req_drop: got %b want %b", {StallF, StallM, FlushW}, 3'b000);
    end
    $display("txn mem_req_drop sf=%b sm=%b", StallF, StallM);
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({MemTimeout, StallM} !== {(k > TO) ? 1'b1 : 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL timeout_cycle%0d: got %b want %b", k, {MemTimeout, StallM},
                 {(k > TO) ? 1'b1 : 1'b0, 1'b1});
      end
      $display("txn timeout_cycle%0d to=%b sm=%b", k, MemTimeout, StallM);
      tick();
    end
    MemReqM = 1'b0; MemReadyM = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({StallF, StallM, FlushW, MemTimeout} !== 4'b1111) begin
      n_bad++;
      $display("FAIL err_frozen: got %b want %b", {StallF, StallM, FlushW, MemTimeout}, 4'b1111);
    end
    $display("txn err_frozen sf=%b to=%b", StallF, MemTimeout);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++;
      $display("FAIL err_async_reset: got %b want %b", obs, RESET_VEC);
    end
    $display("txn err_async_reset obs=%b", obs);
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'b0) begin
      n_bad++;
      $display("FAIL err_cleared: got %b want %b", obs, 12'b0);
    end
    $display("txn err_cleared obs=%b", obs);
    tick();
    // Reset mid-wait must clear the wait count: a fresh miss run needs the full budget again.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    #1 reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      n_cmp++;
      if (MemTimeout !== ((k > TO) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL midwait_reset_cycle%0d: got %b want %b", k, MemTimeout, (k > TO) ? 1'b1 : 1'b0);
      end
      $display("txn midwait_reset_cycle%0d to=%b", k, MemTimeout);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int pct;
    logic [11:0] exp_v;
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 2))
        0:       pct = 95;
        1:       pct = 60;
        default: pct = 3;
      endcase
      for (int c = 0; c < 60; c++) begin
        reset = (c == 0) ? 1'b0 : 1'b1;
        {RA1D, RA2D, RA1E, RA2E} = {rnd_reg(), rnd_reg(), rnd_reg(), rnd_reg()};
        {WA3E, WA3M, WA3W} = {rnd_reg(), rnd_reg(), rnd_reg()};
        RegWriteM    = 1'($urandom_range(0, 1));
        RegWriteW    = 1'($urandom_range(0, 1));
        MemtoRegE    = ($urandom_range(0, 9) < 3);
        PCSrcD       = ($urandom_range(0, 9) == 0);
        PCSrcE       = ($urandom_range(0, 9) == 0);
        PCSrcM       = ($urandom_range(0, 9) == 0);
        PCSrcW       = ($urandom_range(0, 9) == 0);
        BranchTakenE = ($urandom_range(0, 19) < 3);
        MemReqM      = ($urandom_range(0, 9) < 6);
        MemReadyM    = ($urandom_range(0, 99) < pct);
        @(negedge clk);
        exp_v = model_out();
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL random_s%0d_c%0d: got %b want %b", seg, c, obs, exp_v);
        end
        $display("txn random_s%0d_c%0d rst=%b req=%b rdy=%b obs=%b", seg, c, reset, MemReqM, MemReadyM, obs);
        tick();
      end
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_ldstall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
